// File: rtl/ei_balance_monitor.sv
// Windowed E-I balance monitor: per-window L2/3 envelope max/min, mean PV+ inhibition, runaway/silent flags.
// Define EI_MON_CONTINUOUS_EN to run windows back-to-back after a single start.
module ei_balance_monitor #(
  parameter int WIDTH      = 18,
  parameter int FRAC       = 14,
  parameter int WIN_LOG2   = 8,
  parameter int SETTLE_LEN = 500,
  parameter int AMP_HI     = 40000,
  parameter int AMP_LO     = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] l23_x,
  input  logic signed [WIDTH-1:0] l23_y,
  input  logic signed [WIDTH-1:0] pv_total_inhib,
  output logic                    busy,
  output logic                    done,
  output logic        [WIDTH-1:0] amp_max,
  output logic        [WIDTH-1:0] amp_min,
  output logic signed [WIDTH-1:0] inhib_mean,
  output logic                    flag_runaway,
  output logic                    flag_silent,
  output logic        [15:0]      window_count
);

  localparam int ACC_W = WIDTH + WIN_LOG2;
  localparam int CNT_W = (WIN_LOG2 + 1 > $clog2(SETTLE_LEN + 1)) ? WIN_LOG2 + 1 : $clog2(SETTLE_LEN + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'((2 ** WIN_LOG2) - 1);
  localparam logic [WIDTH-1:0] SAT_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MOST_NEG    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AMP_HI_W    = WIDTH'(AMP_HI);
  localparam logic [WIDTH-1:0] AMP_LO_W    = WIDTH'(AMP_LO);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_REPORT} state_t;

  state_t                    state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic        [WIDTH-1:0]   run_max_q, run_max_d;
  logic        [WIDTH-1:0]   run_min_q, run_min_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      done_q, done_d;
  logic        [WIDTH-1:0]   amp_max_q, amp_max_d;
  logic        [WIDTH-1:0]   amp_min_q, amp_min_d;
  logic signed [WIDTH-1:0]   inhib_mean_q, inhib_mean_d;
  logic                      runaway_q, runaway_d;
  logic                      silent_q, silent_d;
  logic        [15:0]        wcount_q, wcount_d;

  logic [WIDTH-1:0] abs_x, abs_y, amp;
  logic [ACC_W-1:0] inhib_ext;

  function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (!v[WIDTH-1])         r = v;
    else if (v == MOST_NEG)  r = SAT_MAX;
    else                     r = -v;
    return r;
  endfunction

  // max + min/2 stays below 1.5 * SAT_MAX, so the WIDTH-bit sum cannot wrap.
  always_comb begin
    abs_x = abs_sat(l23_x);
    abs_y = abs_sat(l23_y);
    if (abs_x >= abs_y) amp = abs_x + (abs_y >> 1);
    else                amp = abs_y + (abs_x >> 1);
    inhib_ext = {{WIN_LOG2{pv_total_inhib[WIDTH-1]}}, pv_total_inhib};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    acc_d        = acc_q;
    done_d       = 1'b0;
    amp_max_d    = amp_max_q;
    amp_min_d    = amp_min_q;
    inhib_mean_d = inhib_mean_q;
    runaway_d    = runaway_q;
    silent_d     = silent_q;
    wcount_d     = wcount_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          run_max_d = '0;
          run_min_d = '1;
          acc_d     = '0;
          state_d   = (SETTLE_LEN == 0) ? S_MEASURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (clk_en) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = S_MEASURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MEASURE: begin
        if (clk_en) begin
          if (amp > run_max_q) run_max_d = amp;
          if ((amp != '0) && (amp < run_min_q)) run_min_d = amp;
          acc_d = acc_q + inhib_ext;
          if (cnt_q == WIN_LAST) begin
            cnt_d   = '0;
            state_d = S_REPORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REPORT: begin
        amp_max_d    = run_max_q;
        // all-ones is unreachable as an amplitude, so it marks "no nonzero sample seen"
        amp_min_d    = (run_min_q == '1) ? '0 : run_min_q;
        inhib_mean_d = acc_q[ACC_W-1:WIN_LOG2];
        runaway_d    = (run_max_q >= AMP_HI_W);
        silent_d     = (run_max_q < AMP_LO_W);
        wcount_d     = (wcount_q == 16'hFFFF) ? wcount_q : wcount_q + 16'd1;
        done_d       = 1'b1;
`ifdef EI_MON_CONTINUOUS_EN
        cnt_d        = '0;
        run_max_d    = '0;
        run_min_d    = '1;
        acc_d        = '0;
        state_d      = S_MEASURE;
`else
        state_d      = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      run_max_q    <= '0;
      run_min_q    <= '1;
      acc_q        <= '0;
      done_q       <= 1'b0;
      amp_max_q    <= '0;
      amp_min_q    <= '0;
      inhib_mean_q <= '0;
      runaway_q    <= 1'b0;
      silent_q     <= 1'b0;
      wcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      acc_q        <= acc_d;
      done_q       <= done_d;
      amp_max_q    <= amp_max_d;
      amp_min_q    <= amp_min_d;
      inhib_mean_q <= inhib_mean_d;
      runaway_q    <= runaway_d;
      silent_q     <= silent_d;
      wcount_q     <= wcount_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign amp_max      = amp_max_q;
  assign amp_min      = amp_min_q;
  assign inhib_mean   = inhib_mean_q;
  assign flag_runaway = runaway_q;
  assign flag_silent  = silent_q;
  assign window_count = wcount_q;

endmodule

// File: tb/tb_ei_balance_monitor.sv
// Randomized bench for ei_balance_monitor with a window-level reference model (8-sample windows).
module tb_ei_balance_monitor;
  localparam int W = 18;
  localparam int WL = 3;
  localparam int N = 8;
`ifdef EI_MON_CONTINUOUS_EN
  localparam int SETTLE = 0;
`else
  localparam int SETTLE = 4;
`endif

  logic clk = 1'b0;
  logic rst, clk_en, start;
  logic signed [W-1:0] l23_x, l23_y, pv_total_inhib;
  logic busy, done, flag_runaway, flag_silent;
  logic [W-1:0] amp_max, amp_min;
  logic signed [W-1:0] inhib_mean;
  logic [15:0] window_count;

  ei_balance_monitor #(.WIDTH(W), .FRAC(14), .WIN_LOG2(WL), .SETTLE_LEN(SETTLE),
                       .AMP_HI(40000), .AMP_LO(1000)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .l23_x(l23_x), .l23_y(l23_y), .pv_total_inhib(pv_total_inhib),
    .busy(busy), .done(done), .amp_max(amp_max), .amp_min(amp_min),
    .inhib_mean(inhib_mean), .flag_runaway(flag_runaway), .flag_silent(flag_silent),
    .window_count(window_count));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_wc = 0;
  int xs[N], ys[N], ns[N];
  int e_max, e_min, e_mean;
  bit e_run, e_sil;
  logic d_pre, d_at, d_post, b_rep, b_post;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int rnd_s18();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 262143)) - 131072;
      1: return int'($urandom_range(0, 3000)) - 1500;
      2: return int'($urandom_range(0, 100000)) - 50000;
      default: return 0;
    endcase
  endfunction

  task automatic drive_garbage();
    l23_x = W'(rnd_s18());
    l23_y = W'(rnd_s18());
    pv_total_inhib = W'(rnd_s18());
  endtask

  function automatic int sat_abs(input int v);
    if (v >= 0) return v;
    return (-v > 131071) ? 131071 : -v;
  endfunction

  // Window statistics straight from the definition: envelope = larger + half of smaller magnitude.
  function automatic void model_window();
    int a, b, amp, sum;
    e_max = 0; e_min = -1; sum = 0;
    for (int i = 0; i < N; i++) begin
      a = sat_abs(xs[i]); b = sat_abs(ys[i]);
      amp = (a > b) ? a + b / 2 : b + a / 2;
      if (amp > e_max) e_max = amp;
      if (amp > 0 && (e_min < 0 || amp < e_min)) e_min = amp;
      sum += ns[i];
    end
    if (e_min < 0) e_min = 0;
    e_mean = (sum >= 0) ? sum / N : -((-sum + N - 1) / N);
    e_run = (e_max >= 40000);
    e_sil = (e_max < 1000);
  endfunction

  task automatic gaps(input int gap_max, input bit start_noise);
    int g;
    g = $urandom_range(0, gap_max);
    for (int i = 0; i < g; i++) begin
      clk_en = 1'b0; drive_garbage();
      start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  // One full start..done sequence; settle samples are loud so leaking them into the window shows up.
  task automatic run_window(input int gap_max, input bit start_mid);
    start = 1'b1; clk_en = 1'($urandom_range(0, 1)); drive_garbage(); tick(); start = 1'b0;
    for (int s = 0; s < SETTLE; s++) begin
      gaps(gap_max, 1'b0);
      clk_en = 1'b1; l23_x = -18'sd131072; l23_y = 18'sd90000; pv_total_inhib = 18'sd77777;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      gaps(gap_max, start_mid);
      clk_en = 1'b1; l23_x = W'(xs[i]); l23_y = W'(ys[i]); pv_total_inhib = W'(ns[i]);
      start = start_mid && (i == 3);
      tick();
      start = 1'b0;
    end
    d_pre = done; b_rep = busy;
    clk_en = 1'($urandom_range(0, 1)); drive_garbage(); tick();
    d_at = done;
    clk_en = 1'b0; tick();
    d_post = done; b_post = busy;
  endtask

  task automatic test_reset();
    int dcount, bcount;
    rst = 1'b1; start = 1'b1; clk_en = 1'b1;
    l23_x = 18'sd12345; l23_y = -18'sd2222; pv_total_inhib = 18'sd999;
    for (int i = 0; i < 10; i++) tick();
    exp_wc = 0;
    n_cmp++; if ({busy, done, flag_runaway, flag_silent} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {busy, done, flag_runaway, flag_silent}); end
    n_cmp++; if ({amp_max, amp_min, inhib_mean, window_count} !== '0) begin n_fail++; $display("FAIL reset_data: got %0d %0d %0d %0d expected all 0", amp_max, amp_min, inhib_mean, window_count); end
    rst = 1'b0; start = 1'b0; dcount = 0; bcount = 0;
    for (int i = 0; i < 100; i++) begin
      clk_en = 1'($urandom_range(0, 1)); drive_garbage(); tick();
      dcount += int'(done); bcount += int'(busy);
    end
    n_cmp++; if (dcount != 0 || bcount != 0) begin n_fail++; $display("FAIL reset_idle: got done=%0d busy=%0d cycles expected 0", dcount, bcount); end
  endtask

`ifndef EI_MON_CONTINUOUS_EN
  task automatic test_constant();
    for (int i = 0; i < N; i++) begin xs[i] = 3000; ys[i] = -1000; ns[i] = 500; end
    run_window(0, 1'b0); exp_wc++;
    n_cmp++; if ({d_pre, d_at, d_post} !== 3'b010) begin n_fail++; $display("FAIL const_done_shape: got %b expected 010", {d_pre, d_at, d_post}); end
    n_cmp++; if (amp_max !== 18'd3500 || amp_min !== 18'd3500) begin n_fail++; $display("FAIL const_amp: got max=%0d min=%0d expected 3500", amp_max, amp_min); end
    n_cmp++; if (inhib_mean !== 18'sd500) begin n_fail++; $display("FAIL const_mean: got %0d expected 500", inhib_mean); end
    n_cmp++; if ({flag_runaway, flag_silent} !== 2'b00) begin n_fail++; $display("FAIL const_flags: got %b expected 00", {flag_runaway, flag_silent}); end
    n_cmp++; if (window_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL const_wc: got %0d expected %0d", window_count, exp_wc); end
    n_cmp++; if (b_rep !== 1'b1 || b_post !== 1'b0) begin n_fail++; $display("FAIL const_busy: got rep=%b after=%b expected 1 0", b_rep, b_post); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < N; i++) begin xs[i] = -131072; ys[i] = 0; ns[i] = -3; end
    run_window(2, 1'b0); exp_wc++;
    n_cmp++; if (amp_max !== 18'd131071 || amp_min !== 18'd131071) begin n_fail++; $display("FAIL sat_amp: got max=%0d min=%0d expected 131071", amp_max, amp_min); end
    n_cmp++; if (flag_runaway !== 1'b1 || flag_silent !== 1'b0) begin n_fail++; $display("FAIL sat_flags: got %b%b expected 10", flag_runaway, flag_silent); end
    n_cmp++; if (inhib_mean !== -18'sd3) begin n_fail++; $display("FAIL sat_mean: got %0d expected -3", inhib_mean); end
  endtask

  task automatic test_silent();
    for (int i = 0; i < N; i++) begin xs[i] = 0; ys[i] = 0; ns[i] = int'($urandom_range(0, 40)) - 20; end
    model_window();
    run_window(2, 1'b0); exp_wc++;
    n_cmp++; if (amp_max !== 18'd0 || amp_min !== 18'd0) begin n_fail++; $display("FAIL silent_amp: got max=%0d min=%0d expected 0", amp_max, amp_min); end
    n_cmp++; if (flag_silent !== 1'b1 || flag_runaway !== 1'b0) begin n_fail++; $display("FAIL silent_flags: got sil=%b run=%b expected 1 0", flag_silent, flag_runaway); end
    n_cmp++; if ($signed(inhib_mean) !== e_mean) begin n_fail++; $display("FAIL silent_mean: got %0d expected %0d", $signed(inhib_mean), e_mean); end
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < N; i++) begin xs[i] = rnd_s18(); ys[i] = rnd_s18(); ns[i] = rnd_s18(); end
      if (w == 1) begin xs[2] = 0; ys[2] = 0; end
      model_window();
      run_window(3, 1'b0); exp_wc++;
      n_cmp++; if ({d_pre, d_at, d_post} !== 3'b010) begin n_fail++; $display("FAIL rand_done w%0d: got %b expected 010", w, {d_pre, d_at, d_post}); end
      n_cmp++; if (amp_max !== W'(e_max) || amp_min !== W'(e_min)) begin n_fail++; $display("FAIL rand_amp w%0d: got %0d/%0d expected %0d/%0d", w, amp_max, amp_min, e_max, e_min); end
      n_cmp++; if ($signed(inhib_mean) !== e_mean) begin n_fail++; $display("FAIL rand_mean w%0d: got %0d expected %0d", w, $signed(inhib_mean), e_mean); end
      n_cmp++; if (flag_runaway !== e_run || flag_silent !== e_sil) begin n_fail++; $display("FAIL rand_flags w%0d: got %b%b expected %b%b", w, flag_runaway, flag_silent, e_run, e_sil); end
      n_cmp++; if (window_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL rand_wc w%0d: got %0d expected %0d", w, window_count, exp_wc); end
      for (int i = 0; i < 5; i++) begin clk_en = 1'($urandom_range(0, 1)); drive_garbage(); tick(); end
      n_cmp++; if (amp_max !== W'(e_max) || $signed(inhib_mean) !== e_mean) begin n_fail++; $display("FAIL rand_hold w%0d: got %0d/%0d expected %0d/%0d", w, amp_max, $signed(inhib_mean), e_max, e_mean); end
    end
  endtask

  task automatic test_start_ignored();
    int dcount;
    for (int i = 0; i < N; i++) begin xs[i] = rnd_s18(); ys[i] = rnd_s18(); ns[i] = rnd_s18(); end
    model_window();
    run_window(2, 1'b1); exp_wc++;
    dcount = int'(d_at);
    for (int i = 0; i < 30; i++) begin clk_en = 1'b1; drive_garbage(); tick(); dcount += int'(done); end
    n_cmp++; if (dcount != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL start_ignored: got dones=%0d busy=%b expected 1 0", dcount, busy); end
    n_cmp++; if (window_count !== 16'(exp_wc) || amp_max !== W'(e_max)) begin n_fail++; $display("FAIL start_ignored_res: got wc=%0d max=%0d expected %0d %0d", window_count, amp_max, exp_wc, e_max); end
  endtask
`else
  task automatic test_continuous();
    int edges[$];
    int bad;
    bad = 0;
    start = 1'b1; clk_en = 1'b1; drive_garbage(); tick(); start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < N; k++) begin
        xs[k] = rnd_s18(); ys[k] = rnd_s18(); ns[k] = rnd_s18();
        clk_en = 1'b1; l23_x = W'(xs[k]); l23_y = W'(ys[k]); pv_total_inhib = W'(ns[k]);
        tick();
        bad += int'(done) + int'(!busy);
      end
      clk_en = 1'b1; drive_garbage(); tick();
      if (done) edges.push_back(cyc);
      model_window(); exp_wc++;
      n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL cont_done w%0d: got done=%b busy=%b expected 1 1", w, done, busy); end
      n_cmp++; if (amp_max !== W'(e_max) || amp_min !== W'(e_min) || $signed(inhib_mean) !== e_mean) begin n_fail++; $display("FAIL cont_res w%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", w, amp_max, amp_min, $signed(inhib_mean), e_max, e_min, e_mean); end
      n_cmp++; if (window_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL cont_wc w%0d: got %0d expected %0d", w, window_count, exp_wc); end
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL cont_between: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (edges.size() != 3) begin n_fail++; $display("FAIL cont_edges: got %0d done pulses expected 3", edges.size()); end
    else begin
      n_cmp++; if (edges[1] - edges[0] != 9 || edges[2] - edges[1] != 9) begin n_fail++; $display("FAIL cont_spacing: got %0d,%0d expected 9,9", edges[1] - edges[0], edges[2] - edges[1]); end
    end
  endtask
`endif

  task automatic test_abort();
    int dcount;
    start = 1'b1; clk_en = 1'b0; drive_garbage(); tick(); start = 1'b0;
    for (int i = 0; i < SETTLE + 3; i++) begin clk_en = 1'b1; drive_garbage(); tick(); end
    rst = 1'b1; clk_en = 1'b1; tick(); exp_wc = 0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_ctl: got busy=%b done=%b expected 0 0", busy, done); end
    n_cmp++; if ({amp_max, amp_min, inhib_mean, window_count, flag_runaway, flag_silent} !== '0) begin n_fail++; $display("FAIL abort_data: got %0d %0d %0d %0d expected all 0", amp_max, amp_min, inhib_mean, window_count); end
    rst = 1'b0; dcount = 0;
    for (int i = 0; i < 40; i++) begin clk_en = 1'b1; drive_garbage(); tick(); dcount += int'(done); end
    n_cmp++; if (dcount != 0) begin n_fail++; $display("FAIL abort_nodone: got %0d done cycles expected 0", dcount); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clk_en = 1'b0;
    l23_x = '0; l23_y = '0; pv_total_inhib = '0;
    test_reset();
`ifndef EI_MON_CONTINUOUS_EN
    test_constant();
    test_saturation();
    test_silent();
    test_random();
    test_start_ignored();
`else
    test_continuous();
`endif
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
